// File: rtl/apb3_bridge_ctrl.sv
// ---------------------------------------------------------------------------
// apb3_bridge_ctrl
//
// Purpose:
//   APB3 master controller for the AHB-to-APB bridge. It takes one AHB-side
//   transfer at a time, runs a SETUP/ACCESS cycle on one of NSLV APB slaves,
//   inserts wait states while the selected slave holds pready low, aborts the
//   access after TIMEOUT wait cycles (TIMEOUT = 0 disables the timeout), and
//   reports slave errors, timeouts and bad slave selects as the two-cycle AHB
//   ERROR response. Every output is driven from a register.
//
// Parameters:
//   AW       address width
//   DW       data width
//   NSLV     number of APB slaves
//   TIMEOUT  max ACCESS cycles waiting for pready, 0 = wait forever
//
// Ports:
//   i_hclk        bridge clock
//   i_hresetn     synchronous reset, active low
//   i_valid       decoded valid AHB transfer (address phase)
//   i_hwrite      1 = write, 0 = read (address phase)
//   i_haddr       transfer address (address phase)
//   i_hwdata      write data (AHB data phase)
//   i_slv_sel     one-hot slave select decoded from haddr
//   o_hready_out  transfer accept / complete to AHB
//   o_hresp       1 = ERROR response
//   o_hrdata      read data, valid in the completion cycle
//   o_psel        APB select, one-hot
//   o_penable     APB enable
//   o_pwrite      APB direction
//   o_paddr       APB address
//   o_pwdata      APB write data
//   i_prdata      slave read data, slave i at [i*DW +: DW]
//   i_pready      slave ready
//   i_pslverr     slave error
// ---------------------------------------------------------------------------
module apb3_bridge_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int NSLV    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              i_hclk,
    input  logic              i_hresetn,
    input  logic              i_valid,
    input  logic              i_hwrite,
    input  logic [AW-1:0]     i_haddr,
    input  logic [DW-1:0]     i_hwdata,
    input  logic [NSLV-1:0]   i_slv_sel,
    output logic              o_hready_out,
    output logic              o_hresp,
    output logic [DW-1:0]     o_hrdata,
    output logic [NSLV-1:0]   o_psel,
    output logic              o_penable,
    output logic              o_pwrite,
    output logic [AW-1:0]     o_paddr,
    output logic [DW-1:0]     o_pwdata,
    input  logic [NSLV*DW-1:0] i_prdata,
    input  logic [NSLV-1:0]   i_pready,
    input  logic [NSLV-1:0]   i_pslverr
);

    // A zero TIMEOUT would give a zero-width counter; keep one bit so the
    // declaration stays legal even though the counter is then never used.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WWAIT,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [NSLV-1:0]   r_sel;
    logic [CW-1:0]     r_count;

    logic              w_accept;
    logic              w_sel_ok;
    logic              w_pready;
    logic              w_pslverr;
    logic [DW-1:0]     w_prdata;
    logic              w_timeout;

    logic              w_hready_next;
    logic              w_hresp_next;
    logic              w_penable_next;
    logic [NSLV-1:0]   w_psel_next;

    assign w_accept = (r_state == S_IDLE) && i_valid && o_hready_out;

    // A select of zero, or with more than one bit set, never reaches the APB.
    assign w_sel_ok = (i_slv_sel != '0) &&
                      ((i_slv_sel & (i_slv_sel - NSLV'(1))) == '0);

    // Only the latched slave's handshake and data are looked at, so an
    // unselected slave driving pready/pslverr has no effect.
    always_comb begin
        w_prdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_sel[i]) begin
                w_prdata = w_prdata | i_prdata[i*DW +: DW];
            end
        end
    end

    assign w_pready  = |(i_pready  & r_sel);
    assign w_pslverr = |(i_pslverr & r_sel);

    // r_count holds the number of pready-low ACCESS cycles already seen, so
    // the current low cycle is the TIMEOUT-th one when r_count + 1 == TIMEOUT.
    assign w_timeout = (TIMEOUT != 0) && ((r_count + CW'(1)) == CW'(TIMEOUT));

    always_ff @(posedge i_hclk) begin
        if (!i_hresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, plus the next value of each registered control output.
    // Outputs are decoded from the next state so that they are valid in the
    // same cycle the state register enters that state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_sel_ok) begin
                        w_next_state = S_ERR1;
                    end else if (i_hwrite) begin
                        w_next_state = S_WWAIT;
                    end else begin
                        w_next_state = S_SETUP;
                    end
                end
            end
            S_WWAIT:  w_next_state = S_SETUP;
            S_SETUP:  w_next_state = S_ACCESS;
            S_ACCESS: begin
                if (w_pready) begin
                    w_next_state = w_pslverr ? S_ERR1 : S_IDLE;
                end else if (w_timeout) begin
                    w_next_state = S_ERR1;
                end
            end
            S_ERR1:   w_next_state = S_ERR2;
            S_ERR2:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase

        w_hready_next  = (w_next_state == S_IDLE) || (w_next_state == S_ERR2);
        w_hresp_next   = (w_next_state == S_ERR1) || (w_next_state == S_ERR2);
        w_penable_next = (w_next_state == S_ACCESS);
        w_psel_next    = '0;
        if ((w_next_state == S_SETUP) || (w_next_state == S_ACCESS)) begin
            // A read goes straight from IDLE to SETUP before r_sel is loaded.
            w_psel_next = w_accept ? i_slv_sel : r_sel;
        end
    end

    always_ff @(posedge i_hclk) begin
        if (!i_hresetn) begin
            o_hready_out <= 1'b1;
            o_hresp      <= 1'b0;
            o_hrdata     <= '0;
            o_psel       <= '0;
            o_penable    <= 1'b0;
            o_pwrite     <= 1'b0;
            o_paddr      <= '0;
            o_pwdata     <= '0;
            r_sel        <= '0;
            r_count      <= '0;
        end else begin
            o_hready_out <= w_hready_next;
            o_hresp      <= w_hresp_next;
            o_psel       <= w_psel_next;
            o_penable    <= w_penable_next;

            if (w_accept) begin
                r_sel    <= i_slv_sel;
                o_paddr  <= i_haddr;
                o_pwrite <= i_hwrite;
            end

            // hwdata arrives in the AHB data phase, one cycle after accept.
            if (r_state == S_WWAIT) begin
                o_pwdata <= i_hwdata;
            end

            if ((r_state == S_ACCESS) && w_pready && !w_pslverr && !o_pwrite) begin
                o_hrdata <= w_prdata;
            end

            if (w_next_state == S_SETUP) begin
                r_count <= '0;
            end else if ((r_state == S_ACCESS) && !w_pready && (TIMEOUT != 0)) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

endmodule
